// File: rtl/keypad_entry_pkg.sv
// Shared encodings for keypad entry: scanner key codes, operator codes, entry states.
package keypad_entry_pkg;

  localparam logic [3:0] KEY_0    = 4'd0;
  localparam logic [3:0] KEY_1    = 4'd1;
  localparam logic [3:0] KEY_2    = 4'd2;
  localparam logic [3:0] KEY_3    = 4'd3;
  localparam logic [3:0] KEY_4    = 4'd4;
  localparam logic [3:0] KEY_5    = 4'd5;
  localparam logic [3:0] KEY_6    = 4'd6;
  localparam logic [3:0] KEY_7    = 4'd7;
  localparam logic [3:0] KEY_8    = 4'd8;
  localparam logic [3:0] KEY_9    = 4'd9;
  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_HASH = 4'd14;
  localparam logic [3:0] KEY_STAR = 4'd15;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_ENTER_A = 2'b00,
    ST_ENTER_B = 2'b01,
    ST_ISSUE   = 2'b10
  } entry_state_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= KEY_9;
  endfunction

  function automatic logic is_operator(input logic [3:0] code);
    return (code >= KEY_A) && (code <= KEY_D);
  endfunction

endpackage

// File: rtl/key_event_filter.sv
// Turns scanner toggles into one-cycle key strobes, suppressing hold-repeat
// toggles of the same key until it has been idle for REARM_CYCLES.
module key_event_filter #(
  parameter int REARM_CYCLES = 5000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] key_code,
  input  logic       key_toggle,
  output logic       key_event,
  output logic [3:0] event_code
);

  localparam int RW = $clog2(REARM_CYCLES + 1);
  localparam logic [RW-1:0] REARM_MAX = RW'(REARM_CYCLES);

  logic          toggle_q;
  logic [3:0]    last_key_q;
  logic [RW-1:0] rearm_q;
  logic          event_q;
  logic [3:0]    code_q;
  logic          raw_ev;
  logic          accept;

  assign raw_ev = key_toggle ^ toggle_q;
  assign accept = raw_ev && ((key_code != last_key_q) || (rearm_q == REARM_MAX));

  // Counter starts saturated so the very first press after reset is always taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle_q   <= 1'b0;
      last_key_q <= 4'd0;
      rearm_q    <= REARM_MAX;
      event_q    <= 1'b0;
      code_q     <= 4'd0;
    end else begin
      toggle_q <= key_toggle;
      event_q  <= accept;
      if (accept) code_q <= key_code;
      if (raw_ev) begin
        last_key_q <= key_code;
        rearm_q    <= '0;
      end else if (rearm_q != REARM_MAX) begin
        rearm_q <= rearm_q + RW'(1);
      end
    end
  end

  assign key_event  = event_q;
  assign event_code = code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry FSM: accumulates two decimal operands and an operator, then
// offers one calculator operation per '#' over a valid/ready handshake.
module keypad_entry
  import keypad_entry_pkg::*;
#(
  parameter int CLOCK_FREQ   = 50000000,
  parameter int REARM_CYCLES = CLOCK_FREQ / 10,
  parameter int MAX_DIGITS   = 4,
  parameter int OPW          = 14
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     key_code,
  input  logic           key_toggle,
  output logic           calc_valid,
  input  logic           calc_ready,
  output logic [OPW-1:0] operand_a,
  output logic [OPW-1:0] operand_b,
  output logic [1:0]     op,
  output logic [OPW-1:0] display_value,
  output logic [1:0]     entry_state
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_DIGITS);

  entry_state_e   state_q;
  logic [OPW-1:0] a_q, b_q;
  logic [1:0]     op_q;
  logic [CW-1:0]  cnt_a_q, cnt_b_q;
  logic           valid_q;

  logic           kev;
  logic [3:0]     kcode;
  logic [OPW+3:0] acc_a, acc_b;
  logic [3:0]     op_code;

  key_event_filter #(.REARM_CYCLES(REARM_CYCLES)) u_filter (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_code   (key_code),
    .key_toggle (key_toggle),
    .key_event  (kev),
    .event_code (kcode)
  );

  // Widened so value*10 + d cannot wrap before truncation back to OPW.
  assign acc_a   = (OPW+4)'(a_q) * (OPW+4)'(10) + (OPW+4)'(kcode);
  assign acc_b   = (OPW+4)'(b_q) * (OPW+4)'(10) + (OPW+4)'(kcode);
  assign op_code = kcode - KEY_A;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ENTER_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_ADD;
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_ENTER_A: if (kev) begin
          if (is_digit(kcode)) begin
            if (cnt_a_q < CNT_MAX) begin
              a_q     <= acc_a[OPW-1:0];
              cnt_a_q <= cnt_a_q + CW'(1);
            end
          end else if (is_operator(kcode)) begin
            op_q    <= op_code[1:0];
            b_q     <= '0;
            cnt_b_q <= '0;
            state_q <= ST_ENTER_B;
          end else if (kcode == KEY_STAR) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
          end
        end
        ST_ENTER_B: if (kev) begin
          if (is_digit(kcode)) begin
            if (cnt_b_q < CNT_MAX) begin
              b_q     <= acc_b[OPW-1:0];
              cnt_b_q <= cnt_b_q + CW'(1);
            end
          end else if (is_operator(kcode)) begin
            if (cnt_b_q == '0) op_q <= op_code[1:0];
          end else if (kcode == KEY_HASH) begin
            valid_q <= 1'b1;
            state_q <= ST_ISSUE;
          end else begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_ADD;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            state_q <= ST_ENTER_A;
          end
        end
        ST_ISSUE: if (calc_ready) begin
          // Key events here are dropped; operands stay frozen until the transfer.
          valid_q <= 1'b0;
          a_q     <= '0;
          b_q     <= '0;
          op_q    <= OP_ADD;
          cnt_a_q <= '0;
          cnt_b_q <= '0;
          state_q <= ST_ENTER_A;
        end
        default: state_q <= ST_ENTER_A;
      endcase
    end
  end

  assign calc_valid    = valid_q;
  assign operand_a     = a_q;
  assign operand_b     = b_q;
  assign op            = op_q;
  assign entry_state   = state_q;
  assign display_value = (state_q == ST_ENTER_A) ? a_q : b_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry; issued operations are checked by a scoreboard monitor.
module tb_keypad_entry;

  localparam int OPW = 14;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [3:0]     key_code;
  logic           key_toggle;
  logic           calc_valid;
  logic           calc_ready;
  logic [OPW-1:0] operand_a, operand_b, display_value;
  logic [1:0]     op, entry_state;

  typedef struct {
    logic [OPW-1:0] a;
    logic [OPW-1:0] b;
    logic [1:0]     op;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;

  always #5 clk = ~clk;

  keypad_entry #(
    .CLOCK_FREQ   (1000),
    .REARM_CYCLES (20),
    .MAX_DIGITS   (4),
    .OPW          (OPW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_code      (key_code),
    .key_toggle    (key_toggle),
    .calc_valid    (calc_valid),
    .calc_ready    (calc_ready),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .op            (op),
    .display_value (display_value),
    .entry_state   (entry_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] code, input int gap);
    key_code   = code;
    key_toggle = ~key_toggle;
    tick(gap);
  endtask

  task automatic push_exp(input logic [OPW-1:0] a, input logic [OPW-1:0] b, input logic [1:0] o);
    exp_t e;
    e.a = a; e.b = b; e.op = o;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every accepted handshake must match the oldest expected op.
  always @(negedge clk) begin
    if (rst_n && calc_valid && calc_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: a=%0d b=%0d op=%0d with no expected entry", operand_a, operand_b, op);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("issue_a", 32'(operand_a), 32'(e.a));
        check("issue_b", 32'(operand_b), 32'(e.b));
        check("issue_op", 32'(op), 32'(e.op));
      end
    end
  end

  initial begin
    rst_n = 1'b0; key_code = 4'd0; key_toggle = 1'b0; calc_ready = 1'b0;
    tick(3);
    check("rst_valid", 32'(calc_valid), 0);
    check("rst_a", 32'(operand_a), 0);
    check("rst_b", 32'(operand_b), 0);
    check("rst_op", 32'(op), 0);
    check("rst_disp", 32'(display_value), 0);
    check("rst_state", 32'(entry_state), 0);
    rst_n = 1'b1;
    tick(2);

    // 123 + 45
    calc_ready = 1'b1;
    press(4'd1, 25); press(4'd2, 25); press(4'd3, 25);
    check("t1_a", 32'(operand_a), 123);
    check("t1_disp_a", 32'(display_value), 123);
    press(4'd10, 25);
    check("t1_state_b", 32'(entry_state), 1);
    check("t1_disp_b0", 32'(display_value), 0);
    press(4'd4, 25); press(4'd5, 25);
    check("t1_disp_b", 32'(display_value), 45);
    push_exp(14'd123, 14'd45, 2'b00);
    press(4'd14, 25);
    check("t1_state_end", 32'(entry_state), 0);
    check("t1_disp_end", 32'(display_value), 0);
    check("t1_valid_end", 32'(calc_valid), 0);

    // Held key 7: repeats within the rearm window are dropped
    for (int i = 0; i < 4; i++) press(4'd7, 5);
    press(4'd7, 25);
    check("t2_hold", 32'(operand_a), 7);
    press(4'd7, 25);
    check("t2_rearm", 32'(operand_a), 77);
    press(4'd15, 25);
    check("t2_clear", 32'(operand_a), 0);

    // Fifth digit ignored, then '*'
    press(4'd9, 25); press(4'd8, 25); press(4'd7, 25); press(4'd6, 25); press(4'd5, 25);
    check("t3_maxdig", 32'(operand_a), 9876);
    press(4'd15, 25);
    check("t3_star_a", 32'(operand_a), 0);
    check("t3_star_state", 32'(entry_state), 0);

    // Operator replacement, ISSUE hold under back-pressure
    press(4'd5, 25); press(4'd12, 25);
    check("t4_op_c", 32'(op), 2);
    press(4'd13, 25);
    check("t4_op_d", 32'(op), 3);
    press(4'd2, 25);
    check("t4_b", 32'(operand_b), 2);
    calc_ready = 1'b0;
    push_exp(14'd5, 14'd2, 2'b11);
    press(4'd14, 5);
    check("t4_state_issue", 32'(entry_state), 2);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("t4_hold_valid", 32'(calc_valid), 1);
      check("t4_hold_a", 32'(operand_a), 5);
    end
    press(4'd15, 25); press(4'd1, 25); press(4'd11, 25);
    check("t4_issue_a", 32'(operand_a), 5);
    check("t4_issue_b", 32'(operand_b), 2);
    check("t4_issue_op", 32'(op), 3);
    check("t4_issue_disp", 32'(display_value), 2);
    check("t4_issue_state", 32'(entry_state), 2);
    calc_ready = 1'b1;
    tick(1);
    check("t4_done_valid", 32'(calc_valid), 0);
    check("t4_done_state", 32'(entry_state), 0);
    check("t4_done_a", 32'(operand_a), 0);
    check("t4_done_op", 32'(op), 0);
    tick(25);

    // '#' in ENTER_A, then A,# with empty operands
    press(4'd14, 25);
    check("t5_hash_state", 32'(entry_state), 0);
    press(4'd10, 25);
    push_exp(14'd0, 14'd0, 2'b00);
    press(4'd14, 25);
    check("t5_end_state", 32'(entry_state), 0);

    // Asynchronous reset while an operation is pending
    calc_ready = 1'b0;
    press(4'd8, 25); press(4'd10, 25); press(4'd1, 25); press(4'd14, 25);
    check("t6_pending", 32'(calc_valid), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(calc_valid), 0);
    check("t6_rst_a", 32'(operand_a), 0);
    check("t6_rst_b", 32'(operand_b), 0);
    check("t6_rst_op", 32'(op), 0);
    check("t6_rst_disp", 32'(display_value), 0);
    check("t6_rst_state", 32'(entry_state), 0);
    key_toggle = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);

    check("handshakes", 32'(hs_cnt), 3);
    check("sb_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Consumes the key code and press-toggle produced by the matrix keypad scanner.
- Turns keypresses into two decimal operands and an operator for the calculator datapath.
- Filters the scanner's hold-repeat toggles, accumulates digits into binary, and issues one operation per '#' through a valid/ready handshake.
- Also drives the value currently being typed to the display path.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- REARM_CYCLES, CLOCK_FREQ/10, idle time after which a repeated identical key counts as a new press. Must exceed one full 4-row scan period (4 x 10 ms).
- MAX_DIGITS, 4, maximum decimal digits per operand.
- OPW, 14, operand width in bits. Must be at least ceil(log2(10^MAX_DIGITS)).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- key_code  in  4  scanner key code: 0-9 digits, 10=A, 11=B, 12=C, 13=D, 14='#', 15='*'. Connect to the low 4 bits of the scanner's 32-bit code.
- key_toggle  in  1  scanner press flag, bit 0; flips once per registered scan hit.
- calc_valid  out  1  operation pending.
- calc_ready  in  1  datapath accepts the operation.
- operand_a  out  OPW  first operand, binary.
- operand_b  out  OPW  second operand, binary.
- op  out  2  operator: 00 add (A), 01 sub (B), 10 mul (C), 11 div (D).
- display_value  out  OPW  operand currently being entered.
- entry_state  out  2  00 ENTER_A, 01 ENTER_B, 10 ISSUE.

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = ENTER_A; all outputs 0.
  - Digit counters cleared; last_key = 0; rearm counter saturated, so the first event is always accepted.
- Event detect:
  - key_toggle registered once (same clock domain).
  - A raw event occurs when key_toggle differs from its registered copy.
  - An event is accepted if key_code differs from last_key, or if the rearm counter has reached REARM_CYCLES.
  - On every raw event, accepted or not, last_key is updated and the rearm counter is cleared.
  - Otherwise the rearm counter increments, saturating at REARM_CYCLES.
  - An accepted event is processed the cycle after the toggle edge is seen (1-cycle latency).
- ENTER_A:
  - Digit d: if digit count < MAX_DIGITS, operand_a <= operand_a*10 + d and count increments; otherwise ignored.
  - A/B/C/D: op <= code - 10; go to ENTER_B with operand_b = 0 and count_b = 0. Allowed with zero digits entered (operand_a = 0).
  - '#': ignored.
  - '*': clear operands, op and counts; stay in ENTER_A.
- ENTER_B:
  - Digit d: same accumulation rule, applied to operand_b.
  - Operator key: if count_b = 0, replace op; otherwise ignored.
  - '#': go to ISSUE; calc_valid = 1 from the next cycle.
  - '*': clear everything; go to ENTER_A.
- ISSUE:
  - calc_valid stays high; operand_a, operand_b and op are held stable.
  - Transfer completes on a cycle with calc_valid & calc_ready. Next cycle: calc_valid = 0, state ENTER_A, operands/op/counts cleared.
  - All accepted key events in ISSUE are discarded, including '*'. Event detect and rearm logic keep running.
- display_value:
  - operand_a in ENTER_A.
  - operand_b in ENTER_B, including 0 right after the operator.
  - operand_b in ISSUE.
- Arithmetic:
  - value*10 + d is computed at OPW+4 bits and truncated to OPW.
  - Because of MAX_DIGITS, the result never exceeds 10^MAX_DIGITS - 1.
- Simultaneous events: a raw event and a handshake in the same cycle resolve as handshake first; the event is discarded.
- Reset mid-operation: everything returns to its reset values, including an in-flight calc_valid.

Decomposition:
- Shared package holds:
  - key code constants KEY_0..KEY_9, KEY_A..KEY_D, KEY_HASH, KEY_STAR (matching the scanner encoding);
  - op encodings OP_ADD, OP_SUB, OP_MUL, OP_DIV;
  - entry_state encodings.
- One sub-module: key_event_filter. It owns the toggle edge detection, last_key and the rearm counter, and outputs a one-cycle key_event strobe plus the event's key code.

Test Plan:
- All directed tests use REARM_CYCLES = 20.
- Press 1,2,3,A,4,5,# (toggle each, gaps > 20 cycles), calc_ready = 1 -> one calc_valid pulse with operand_a = 123, operand_b = 45, op = 00; then entry_state = 00 and display_value = 0.
- Key 7 held: five toggles 5 cycles apart -> operand_a = 7 only. Same key again after a 25-cycle gap -> operand_a = 77.
- Digits 9,8,7,6,5 -> operand_a = 9876 (fifth digit ignored). Then '*' -> operand_a = 0, entry_state = 00.
- 5,C,D,2,# -> op = 11 (replaced before any B digit), operand_b = 2. Then hold calc_ready = 0 for 10 cycles -> calc_valid and operands stable, and key presses during ISSUE have no effect. Raise calc_ready -> clears next cycle.
- '#' in ENTER_A -> no state change. A,# -> issue with operand_a = 0, operand_b = 0, op = 00.
- Assert rst_n low while calc_valid = 1 -> calc_valid = 0 immediately (asynchronous), all outputs 0, entry_state = 00.
